hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_cnt.sv | 36 +++
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_cnt.sv
// ============================================================================
//  Module      : hazard_ctrl_cnt
//  Description : Saturating up-counter with synchronous clear and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Clear wins over enable so an exit cycle never leaves a stale count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline interlock/flush controller (load-use, dmem wait,
//                taken branch) for the 5-stage core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MAX_WAIT        = 64,
    parameter int CNT_W           = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 D_USE_RS1,
    input  logic                 D_USE_RS2,
    input  logic [REG_IDX_W-1:0] exerd,
    input  logic                 E_MEMREAD,
    input  logic                 E_REGWRITE,
    input  logic                 E_BRTAKEN,
    input  logic                 dmem_busy,
    output logic                 pc_stall,
    output logic                 fd_stall,
    output logic                 de_stall,
    output logic                 em_stall,
    output logic                 fd_flush,
    output logic                 de_flush,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int         WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [1:0] LU_LOAD = 2'(LU_STALL_CYCLES - 1);

    hz_state_t         r_state;
    hz_state_t         w_next;
    logic [1:0]        r_lu_cnt;
    logic              r_mem_timeout;
    logic [WAIT_W-1:0] w_wait_cnt;

    logic w_lu_hit;
    logic w_eval_run;
    logic w_lu_load;
    logic w_lu_dec;
    logic w_wait_en;
    logic w_wait_reach;
    logic w_pc, w_fd, w_de, w_em, w_fdf, w_def;

    assign w_lu_hit = E_MEMREAD && E_REGWRITE && (exerd != REG_ZERO) &&
                      ((D_USE_RS1 && (rs1 == exerd)) ||
                       (D_USE_RS2 && (rs2 == exerd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_eval_run = 1'b0;
        w_lu_load  = 1'b0;
        w_lu_dec   = 1'b0;
        w_pc       = 1'b0;
        w_fd       = 1'b0;
        w_de       = 1'b0;
        w_em       = 1'b0;
        w_fdf      = 1'b0;
        w_def      = 1'b0;

        case (r_state)
            RUN: begin
                w_eval_run = 1'b1;
            end
            LU_STALL: begin
                if (dmem_busy) begin
                    {w_pc, w_fd, w_de, w_em} = 4'b1111;
                end else begin
                    {w_pc, w_fd, w_def} = 3'b111;
                    w_lu_dec = 1'b1;
                    if (r_lu_cnt == 2'd1) begin
                        w_next = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    {w_pc, w_fd, w_de, w_em} = 4'b1111;
                end else begin
                    // Leaving the freeze: this cycle is judged as a RUN cycle.
                    w_next     = RUN;
                    w_eval_run = 1'b1;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase

        if (w_eval_run) begin
            if (dmem_busy) begin
                {w_pc, w_fd, w_de, w_em} = 4'b1111;
                w_next = MEM_WAIT;
            end else if (E_BRTAKEN) begin
                {w_fdf, w_def} = 2'b11;
            end else if (w_lu_hit) begin
                {w_pc, w_fd, w_def} = 3'b111;
                if (LU_STALL_CYCLES > 1) begin
                    w_next    = LU_STALL;
                    w_lu_load = 1'b1;
                end
            end
        end

        if (rst) begin
            {w_pc, w_fd, w_de, w_em, w_fdf, w_def} = 6'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_cnt <= 2'd0;
        end else if (w_lu_load) begin
            r_lu_cnt <= LU_LOAD;
        end else if (w_lu_dec) begin
            r_lu_cnt <= r_lu_cnt - 2'd1;
        end
    end

    // A busy cycle in LU_STALL is a freeze of the bubble sequence, not a
    // memory wait, so it neither counts nor clears the wait counter.
    assign w_wait_en    = dmem_busy && (r_state != LU_STALL);
    assign w_wait_reach = w_wait_en &&
                          ((32'(w_wait_cnt) + 32'd1) >= 32'(MAX_WAIT));

    hazard_ctrl_cnt #(
        .WIDTH (WAIT_W),
        .MAX   (WAIT_W'(MAX_WAIT))
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_wait_en),
        .i_clr (~dmem_busy),
        .o_cnt (w_wait_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_timeout <= 1'b0;
        end else if (w_wait_reach) begin
            r_mem_timeout <= 1'b1;
        end
    end

    hazard_ctrl_cnt #(
        .WIDTH (CNT_W),
        .MAX   ('1)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_pc),
        .i_clr (1'b0),
        .o_cnt (stall_cnt)
    );

    assign pc_stall    = w_pc;
    assign fd_stall    = w_fd;
    assign de_stall    = w_de;
    assign em_stall    = w_em;
    assign fd_flush    = w_fdf;
    assign de_flush    = w_def;
    assign mem_timeout = r_mem_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl, LU_STALL_CYCLES = 1, 2, 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    // Output vector order: {pc, fd, de, em, fd_flush, de_flush, mem_timeout}
    localparam logic [6:0] E_Z   = 7'b0000000;
    localparam logic [6:0] E_ZT  = 7'b0000001;
    localparam logic [6:0] E_S4  = 7'b1111000;
    localparam logic [6:0] E_S4T = 7'b1111001;
    localparam logic [6:0] E_LU  = 7'b1100010;
    localparam logic [6:0] E_BR  = 7'b0000110;

    typedef struct {
        int          id;
        int          sel;
        logic [6:0]  outs;
        logic [31:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, exerd = '0;
    logic       D_USE_RS1 = 1'b0, D_USE_RS2 = 1'b0;
    logic       E_MEMREAD = 1'b0, E_REGWRITE = 1'b0, E_BRTAKEN = 1'b0;
    logic       dmem_busy = 1'b0;

    logic        pc[3], fd[3], de[3], em[3], fdf[3], def[3], to[3];
    logic [31:0] cnt[3];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sid    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl #(
            .LU_STALL_CYCLES (g + 1),
            .MAX_WAIT        (64),
            .CNT_W           (32)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .rs1         (rs1),
            .rs2         (rs2),
            .D_USE_RS1   (D_USE_RS1),
            .D_USE_RS2   (D_USE_RS2),
            .exerd       (exerd),
            .E_MEMREAD   (E_MEMREAD),
            .E_REGWRITE  (E_REGWRITE),
            .E_BRTAKEN   (E_BRTAKEN),
            .dmem_busy   (dmem_busy),
            .pc_stall    (pc[g]),
            .fd_stall    (fd[g]),
            .de_stall    (de[g]),
            .em_stall    (em[g]),
            .fd_flush    (fdf[g]),
            .de_flush    (def[g]),
            .mem_timeout (to[g]),
            .stall_cnt   (cnt[g])
        );
    end

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc[e.sel], fd[e.sel], de[e.sel], em[e.sel],
                   fdf[e.sel], def[e.sel], to[e.sel]};
            checks++;
            if (act !== e.outs) begin
                errors++;
                $display("FAIL step%0d dut%0d outs actual=%b required=%b",
                         e.id, e.sel, act, e.outs);
            end
            checks++;
            if (cnt[e.sel] !== e.cnt) begin
                errors++;
                $display("FAIL step%0d dut%0d stall_cnt actual=%0d required=%0d",
                         e.id, e.sel, cnt[e.sel], e.cnt);
            end
            checks++;
            if (((fd[e.sel] & fdf[e.sel]) | (de[e.sel] & def[e.sel])) !== 1'b0) begin
                errors++;
                $display("FAIL step%0d dut%0d flush_vs_stall actual=%b%b%b%b required=no overlap",
                         e.id, e.sel, fd[e.sel], fdf[e.sel], de[e.sel], def[e.sel]);
            end
        end
    end

    task automatic step(input int sel, input logic r, input logic b, input logic br,
                        input logic [1:0] mw, input logic [4:0] rd,
                        input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2,
                        input logic [6:0] eo, input int ec);
        exp_t e;
        rst        = r;
        dmem_busy  = b;
        E_BRTAKEN  = br;
        E_MEMREAD  = mw[1];
        E_REGWRITE = mw[0];
        exerd      = rd;
        rs1        = s1;
        D_USE_RS1  = u1;
        rs2        = s2;
        D_USE_RS2  = u2;
        sid++;
        e.id   = sid;
        e.sel  = sel;
        e.outs = eo;
        e.cnt  = 32'(ec);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int sel, input logic [6:0] eo, input int ec);
        step(sel, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, eo, ec);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // LU_STALL_CYCLES = 1: reset gating, single bubble, non-hazard cases
        step(0, 1, 1, 0, 2'b11, 5, 5, 1, 0, 0, E_Z, 0);
        idle(0, E_Z, 0);
        step(0, 0, 0, 0, 2'b11, 5, 5, 1, 0, 0, E_LU, 0);
        step(0, 0, 0, 0, 2'b00, 5, 5, 1, 0, 0, E_Z, 1);
        step(0, 0, 0, 0, 2'b11, 0, 0, 1, 0, 0, E_Z, 1);
        step(0, 0, 0, 0, 2'b11, 5, 6, 1, 0, 0, E_Z, 1);
        step(0, 0, 0, 0, 2'b11, 5, 5, 0, 5, 0, E_Z, 1);
        step(0, 0, 0, 0, 2'b10, 5, 5, 1, 0, 0, E_Z, 1);
        step(0, 0, 0, 0, 2'b11, 9, 1, 0, 9, 1, E_LU, 1);
        idle(0, E_Z, 2);

        // LU_STALL_CYCLES = 2: two bubbles, branch priority, MEM_WAIT exits
        step(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, E_Z, 0);
        step(1, 0, 0, 0, 2'b11, 7, 0, 0, 7, 1, E_LU, 0);
        idle(1, E_LU, 1);
        idle(1, E_Z, 2);
        step(1, 0, 0, 1, 2'b11, 7, 0, 0, 7, 1, E_BR, 2);
        idle(1, E_Z, 2);
        step(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4, 2);
        step(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, E_BR, 3);
        idle(1, E_Z, 3);
        step(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4, 3);
        step(1, 0, 0, 0, 2'b11, 7, 7, 1, 0, 0, E_LU, 4);
        idle(1, E_LU, 5);
        idle(1, E_Z, 6);

        // LU_STALL_CYCLES = 3: dmem_busy freezes the bubble sequence
        step(2, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, E_Z, 0);
        step(2, 0, 0, 0, 2'b11, 3, 3, 1, 0, 0, E_LU, 0);
        for (int k = 1; k <= 3; k++) begin
            step(2, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4, k);
        end
        idle(2, E_LU, 4);
        idle(2, E_LU, 5);
        idle(2, E_Z, 6);

        // Timeout after 64 busy cycles, sticky, cleared only by reset
        step(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, E_Z, 0);
        for (int k = 1; k <= 64; k++) begin
            step(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4, k - 1);
        end
        idle(0, E_ZT, 64);
        idle(0, E_ZT, 64);
        step(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4T, 64);
        step(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_S4T, 65);
        step(0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0, E_Z, 0);
        idle(0, E_Z, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
